// File: rtl/riscv_defs.sv
// ============================================================================
// riscv_defs : shared widths and the data-memory arbiter state encoding.
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_defs;

  localparam int NB_WORD = 32;
  localparam int NB_ADDR = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_if.sv
// ============================================================================
// dmem_if : single-port data memory bus; read data arrives one cycle after
//           the address. Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_if import riscv_defs::*; ();

  logic [NB_ADDR-1:0] dmem_address;
  logic [NB_WORD-1:0] dmem_wr_data;
  logic               dmem_wr_enable;
  logic [NB_WORD-1:0] dmem_rd_data;

  modport cpu (
    output dmem_address,
    output dmem_wr_data,
    output dmem_wr_enable,
    input  dmem_rd_data
  );

  modport mem (
    input  dmem_address,
    input  dmem_wr_data,
    input  dmem_wr_enable,
    output dmem_rd_data
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arb_picker.sv
// ============================================================================
// dmem_arb_picker : combinational two-port winner select. Round-robin when
//                   DMEM_ARB_RR_EN is defined, else port 0 has priority. Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arb_picker (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_winner
);

`ifdef DMEM_ARB_RR_EN
  // On contention favour the port that was not granted last.
  always_comb begin
    o_winner = i_valid[1];
    if (&i_valid) begin
      o_winner = ~i_last_grant;
    end
  end
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
  assign o_winner            = i_valid[1] & ~i_valid[0];
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares one data memory between the CPU (port 0) and a
//                loader (port 1); fixed 3-cycle IDLE/ACCESS/RESP transaction.
//                Arbitration mode selected by macro DMEM_ARB_RR_EN. Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter import riscv_defs::*; (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_req0_valid,
  input  logic               i_req0_wr,
  input  logic [NB_ADDR-1:0] i_req0_addr,
  input  logic [NB_WORD-1:0] i_req0_wdata,
  input  logic               i_req1_valid,
  input  logic               i_req1_wr,
  input  logic [NB_ADDR-1:0] i_req1_addr,
  input  logic [NB_WORD-1:0] i_req1_wdata,
  output logic               o_req0_ready,
  output logic               o_req1_ready,
  output logic               o_rsp0_valid,
  output logic               o_rsp1_valid,
  output logic [NB_WORD-1:0] o_rsp_rdata,
  output logic               o_busy,
  dmem_if.cpu                dmem_bus
);

  arb_state_t         r_state;
  arb_state_t         w_next_state;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_WORD-1:0] r_wdata;
  logic               r_wr;
  logic               r_owner;
  logic               r_last_grant;

  logic [1:0]         w_valid;
  logic               w_winner;
  logic               w_accept;
  logic               w_in_access;
  logic               w_in_resp;

  assign w_valid = {i_req1_valid, i_req0_valid};

  dmem_arb_picker u_picker (
    .i_valid      (w_valid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Ready is withheld while reset is asserted so no accept is ever advertised
  // on a cycle whose edge will discard it.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (i_reset && (|w_valid)) begin
          w_accept     = 1'b1;
          o_req0_ready = ~w_winner;
          o_req1_ready = w_winner;
          w_next_state = ARB_ACCESS;
        end
      end
      ARB_ACCESS: w_next_state = ARB_RESP;
      ARB_RESP:   w_next_state = ARB_IDLE;
      default:    w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wr         <= 1'b0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_addr       <= w_winner ? i_req1_addr  : i_req0_addr;
      r_wdata      <= w_winner ? i_req1_wdata : i_req0_wdata;
      r_wr         <= w_winner ? i_req1_wr    : i_req0_wr;
      r_owner      <= w_winner;
      r_last_grant <= w_winner;
    end
  end

  assign w_in_access = (r_state == ARB_ACCESS);
  assign w_in_resp   = (r_state == ARB_RESP);

  // Write enable is also gated by reset so a store interrupted in its
  // ACCESS cycle never reaches memory.
  assign dmem_bus.dmem_address   = w_in_access ? r_addr  : '0;
  assign dmem_bus.dmem_wr_data   = w_in_access ? r_wdata : '0;
  assign dmem_bus.dmem_wr_enable = w_in_access & r_wr & i_reset;

  assign o_rsp0_valid = w_in_resp & ~r_owner;
  assign o_rsp1_valid = w_in_resp & r_owner;
  assign o_rsp_rdata  = (w_in_resp && !r_wr) ? dmem_bus.dmem_rd_data : '0;
  assign o_busy       = (r_state != ARB_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : directed vector table plus hand sequences for the
//                   dmem_arbiter, with a behavioural synchronous memory. Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_wr, req1_valid, req1_wr;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp_rdata;

  logic [31:0] mem [0:255];
  int          n_checks;
  int          n_errors;

  dmem_if u_if ();

  dmem_arbiter u_dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_req0_valid (req0_valid),
    .i_req0_wr    (req0_wr),
    .i_req0_addr  (req0_addr),
    .i_req0_wdata (req0_wdata),
    .i_req1_valid (req1_valid),
    .i_req1_wr    (req1_wr),
    .i_req1_addr  (req1_addr),
    .i_req1_wdata (req1_wdata),
    .o_req0_ready (req0_ready),
    .o_req1_ready (req1_ready),
    .o_rsp0_valid (rsp0_valid),
    .o_rsp1_valid (rsp1_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_busy       (busy),
    .dmem_bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (u_if.dmem_wr_enable) mem[u_if.dmem_address[7:0]] <= u_if.dmem_wr_data;
    u_if.dmem_rd_data <= mem[u_if.dmem_address[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v0;
    logic        wr0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        v1;
    logic        wr1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        own_fp;
    logic        own_rr;
    logic [31:0] rd_fp;
    logic [31:0] rd_rr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  // Entered just after a negedge with the DUT in IDLE; leaves it the same way.
  task automatic run_txn(input vec_t v);
    logic        own, ew;
    logic [31:0] erd, ea, ed;
    own = RR ? v.own_rr : v.own_fp;
    erd = RR ? v.rd_rr  : v.rd_fp;
    ea  = own ? v.a1  : v.a0;
    ed  = own ? v.d1  : v.d0;
    ew  = own ? v.wr1 : v.wr0;
    req0_valid = v.v0; req0_wr = v.wr0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_wr = v.wr1; req1_addr = v.a1; req1_wdata = v.d1;
    #1;
    chk("idle_ready0", req0_ready, !own);
    chk("idle_ready1", req1_ready, own);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    req0_valid = 1'b0; req0_wr = ~v.wr0; req0_addr = 32'hFFFF_FFF0; req0_wdata = 32'h0BAD_0BAD;
    req1_valid = 1'b0; req1_wr = ~v.wr1; req1_addr = 32'hFFFF_FFF4; req1_wdata = 32'h0BAD_1BAD;
    #1;
    chk("access_addr", u_if.dmem_address, ea);
    chk("access_wdata", u_if.dmem_wr_data, ed);
    chk("access_we", u_if.dmem_wr_enable, ew);
    chk("access_busy", busy, 1);
    @(negedge clk); #1;
    chk("resp_valid0", rsp0_valid, !own);
    chk("resp_valid1", rsp1_valid, own);
    chk("resp_rdata", rsp_rdata, erd);
    chk("resp_we", u_if.dmem_wr_enable, 0);
    @(negedge clk); #1;
    chk("post_busy", busy, 0);
    chk("post_rsp", {rsp1_valid, rsp0_valid}, 0);
    chk("post_addr", u_if.dmem_address, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    idle_inputs();
    rst_n = 1'b0;

    vecs[0] = '{1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0};
    vecs[1] = '{1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{0, 0, 32'h0, 32'h0, 1, 1, 32'h24, 32'hCAFEF00D, 1, 1, 32'h0, 32'h0};
    vecs[3] = '{0, 0, 32'h0, 32'h0, 1, 0, 32'h24, 32'h0, 1, 1, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[4] = '{1, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0, 0, 0, 32'h10000020, 32'h10000020};
    vecs[5] = '{1, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0, 0, 1, 32'h10000020, 32'hCAFEF00D};
    vecs[6] = '{1, 1, 32'h30, 32'h11111111, 1, 1, 32'h30, 32'h22222222, 0, 0, 32'h0, 32'h0};
    vecs[7] = '{1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h11111111, 32'h11111111};

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_rsp", {rsp1_valid, rsp0_valid}, 0);
    chk("reset_we", u_if.dmem_wr_enable, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_addr", u_if.dmem_address, 0);
    chk("idle_wdata", u_if.dmem_wr_data, 0);
    chk("idle_we", u_if.dmem_wr_enable, 0);
    chk("idle_noready", {req1_ready, req0_ready}, 0);
    chk("idle_nobusy", busy, 0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);
    idle_inputs();

    // Port 1 arrives while port 0 owns the memory, then changes after accept.
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 32'h20;
    #1;
    chk("hold_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 32'h24;
    #1;
    chk("hold_ready1_access", req1_ready, 0);
    @(negedge clk); #1;
    chk("hold_ready1_resp", req1_ready, 0);
    chk("hold_rsp0", rsp0_valid, 1);
    chk("hold_rdata0", rsp_rdata, 32'h10000020);
    @(negedge clk); #1;
    chk("hold_ready1_idle", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0; req1_addr = 32'h99; req1_wr = 1'b1; req1_wdata = 32'h12345678;
    #1;
    chk("capt_addr", u_if.dmem_address, 32'h24);
    chk("capt_we", u_if.dmem_wr_enable, 0);
    @(negedge clk); #1;
    chk("capt_rsp1", rsp1_valid, 1);
    chk("capt_rdata", rsp_rdata, 32'hCAFEF00D);
    @(negedge clk);
    idle_inputs();

    // Reset lands in the ACCESS cycle of a store.
    req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 32'h10; req0_wdata = 32'h55555555;
    #1;
    chk("rst_store_ready", req0_ready, 1);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_access_we", u_if.dmem_wr_enable, 0);
    @(negedge clk); #1;
    chk("rst_after_busy", busy, 0);
    chk("rst_after_rsp", {rsp1_valid, rsp0_valid}, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_no_late_rsp", {rsp1_valid, rsp0_valid}, 0);
    run_txn('{0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF});

    // Both ports held valid: last grant is port 1 here.
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 32'h20;
    req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 32'h24;
    for (int k = 0; k < 4; k++) begin
      logic eg;
      eg = RR ? k[0] : 1'b0;
      #1;
      chk("cont_ready0", req0_ready, !eg);
      chk("cont_ready1", req1_ready, eg);
      @(negedge clk); #1;
      chk("cont_access_ready", {req1_ready, req0_ready}, 0);
      @(negedge clk); #1;
      chk("cont_rsp0", rsp0_valid, !eg);
      chk("cont_rsp1", rsp1_valid, eg);
      chk("cont_rdata", rsp_rdata, eg ? 32'hCAFEF00D : 32'h10000020);
      @(negedge clk);
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
